// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states and
// byte-lane helper functions used by both the store merge and load extraction.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } lsu_state_e;

  // True for an illegal size or an access not aligned to its own size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // One bit per little-endian byte lane touched by the access.
  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] en;
    case (size)
      SZ_BYTE: en = 4'b0001 << offset;
      SZ_HALF: en = 4'b0011 << {offset[1], 1'b0};
      SZ_WORD: en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

  // Expand a lane-enable vector into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] en);
    return {{8{en[3]}}, {8{en[2]}}, {8{en[1]}}, {8{en[0]}}};
  endfunction

  // Bit distance from bit 0 to the first selected lane.
  function automatic logic [4:0] lane_shift(input logic [1:0] offset);
    return {offset, 3'b000};
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane merge: places right-aligned store data into the
// selected lanes of an existing word, leaving the other lanes untouched.
module byte_lane_merge
  import lsu_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] store_data_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  output logic [31:0] merged_o,
  output logic [3:0]  lane_en_o
);

  logic [31:0] shifted_s;
  logic [31:0] mask_s;

  // Select lanes, align store data to them and blend with the old word.
  always_comb begin
    lane_en_o = lane_enable(size_i, offset_i);
    mask_s    = lane_mask(lane_en_o);
    shifted_s = store_data_i << lane_shift(offset_i);
    merged_o  = (shifted_s & mask_s) | (old_word_i & ~mask_s);
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed RAM. One request
// at a time; sub-word stores are read-modify-write, loads are extended.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int AW = 24
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Req,
  input  logic          Write,
  input  logic [AW+1:0] Addr,
  input  logic [1:0]    Size,
  input  logic          Signed,
  input  logic [31:0]   StoreData,
  output logic          Ready,
  output logic          Done,
  output logic          Fault,
  output logic [31:0]   LoadData,
  output logic [AW-1:0] MemAddress,
  output logic [31:0]   MemWriteData,
  output logic          MemWE,
  output logic          MemRE,
  input  logic [31:0]   MemReadData
);

  lsu_state_e    state_q, state_d;
  logic          write_q, write_d;
  logic          signed_q, signed_d;
  logic          fault_q, fault_d;
  logic [1:0]    size_q, size_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   sdata_q, sdata_d;
  logic [31:0]   load_data_q, load_data_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;

  logic [31:0]   merged_s;
  logic [3:0]    lane_en_s;
  logic [31:0]   aligned_s;
  logic [31:0]   load_ext_s;

  // The merge sees the RAM word only while it is being read.
  byte_lane_merge u_merge (
    .old_word_i   (MemReadData),
    .store_data_i (sdata_q),
    .size_i       (size_q),
    .offset_i     (addr_q[1:0]),
    .merged_o     (merged_s),
    .lane_en_o    (lane_en_s)
  );

  // Extract the selected lanes of the read word, right-align and extend.
  always_comb begin
    aligned_s = (MemReadData & lane_mask(lane_en_s)) >> lane_shift(addr_q[1:0]);
    case (size_q)
      SZ_BYTE: load_ext_s = {{24{signed_q & aligned_s[7]}}, aligned_s[7:0]};
      SZ_HALF: load_ext_s = {{16{signed_q & aligned_s[15]}}, aligned_s[15:0]};
      default: load_ext_s = aligned_s;
    endcase
  end

  // Next-state and datapath update for the request FSM.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    signed_d    = signed_q;
    fault_d     = fault_q;
    size_d      = size_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    load_data_d = load_data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (Req) begin
          write_d  = Write;
          signed_d = Signed;
          size_d   = Size;
          addr_d   = Addr;
          sdata_d  = StoreData;
          fault_d  = misaligned(Size, Addr[1:0]);
          if (misaligned(Size, Addr[1:0])) begin
            state_d = ST_DONE;
          end else if (Write && (Size == SZ_WORD)) begin
            // Full-word store needs no read; write data is known now.
            state_d     = ST_WRITE;
            mem_addr_d  = Addr[AW+1:2];
            mem_wdata_d = StoreData;
          end else begin
            state_d    = ST_READ;
            mem_addr_d = Addr[AW+1:2];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (write_q) begin
          state_d     = ST_WRITE;
          mem_wdata_d = merged_s;
        end else begin
          state_d     = ST_DONE;
          load_data_d = load_ext_s;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears every observable output.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      signed_q    <= 1'b0;
      fault_q     <= 1'b0;
      size_q      <= 2'b00;
      addr_q      <= '0;
      sdata_q     <= 32'h0000_0000;
      load_data_q <= 32'h0000_0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      signed_q    <= signed_d;
      fault_q     <= fault_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      load_data_q <= load_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign Ready        = (state_q == ST_IDLE);
  assign Done         = (state_q == ST_DONE);
  assign Fault        = (state_q == ST_DONE) & fault_q;
  assign MemRE        = (state_q == ST_READ);
  assign MemWE        = (state_q == ST_WRITE);
  assign LoadData     = load_data_q;
  assign MemAddress   = mem_addr_q;
  assign MemWriteData = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small behavioural RAM.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int AW = 24;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Req = 1'b0;
  logic          Write = 1'b0;
  logic [AW+1:0] Addr = '0;
  logic [1:0]    Size = 2'b00;
  logic          Signed = 1'b0;
  logic [31:0]   StoreData = 32'h0;
  logic          Ready, Done, Fault, MemWE, MemRE;
  logic [31:0]   LoadData, MemWriteData, MemReadData;
  logic [AW-1:0] MemAddress;

  logic [31:0] mem [0:63];
  int checks = 0;
  int failures = 0;

  int            lat, we_cnt, re_cnt, we_cyc;
  logic          flt;
  logic [AW-1:0] we_addr;
  logic [31:0]   prev;

  load_store_unit #(.AW(AW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req(Req), .Write(Write), .Addr(Addr),
    .Size(Size), .Signed(Signed), .StoreData(StoreData), .Ready(Ready),
    .Done(Done), .Fault(Fault), .LoadData(LoadData), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .MemWE(MemWE), .MemRE(MemRE),
    .MemReadData(MemReadData)
  );

  always #5 Clk = ~Clk;

  assign MemReadData = mem[MemAddress[5:0]];
  always @(posedge Clk) if (MemWE) mem[MemAddress[5:0]] <= MemWriteData;

  // Issue one request and observe it up to its Done pulse (bounded).
  task automatic do_req(input logic wr, input logic [AW+1:0] a, input logic [1:0] sz,
                        input logic sg, input logic [31:0] d);
    @(negedge Clk);
    Req = 1'b1; Write = wr; Addr = a; Size = sz; Signed = sg; StoreData = d;
    @(posedge Clk);
    #1 Req = 1'b0;
    lat = 0; flt = 1'b0; we_cnt = 0; re_cnt = 0; we_cyc = 0; we_addr = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      if (MemWE) begin we_cnt++; we_cyc = c; we_addr = MemAddress; end
      if (MemRE) re_cnt++;
      if (Done) begin lat = c; flt = Fault; break; end
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    #12;
    checks++; if (Ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b exp 1", Ready); end
    checks++; if ({Done, Fault, MemWE, MemRE} !== 4'b0000) begin failures++; $display("FAIL reset_flags got %b exp 0000", {Done, Fault, MemWE, MemRE}); end
    checks++; if (LoadData !== 32'h0) begin failures++; $display("FAIL reset_loaddata got %h exp 0", LoadData); end
    checks++; if (MemAddress !== 24'h0 || MemWriteData !== 32'h0) begin failures++; $display("FAIL reset_mem got %h/%h exp 0/0", MemAddress, MemWriteData); end
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  task automatic test_word_store_load();
    do_req(1'b1, 26'h24, SZ_WORD, 1'b0, 32'hDEADBEEF);
    checks++; if (lat !== 2) begin failures++; $display("FAIL wstore_latency got %0d exp 2", lat); end
    checks++; if (we_cnt !== 1 || we_addr !== 24'd9 || re_cnt !== 0) begin failures++; $display("FAIL wstore_mem got we=%0d addr=%0d re=%0d exp 1/9/0", we_cnt, we_addr, re_cnt); end
    checks++; if (flt !== 1'b0) begin failures++; $display("FAIL wstore_fault got %b exp 0", flt); end
    @(negedge Clk);
    checks++; if (mem[9] !== 32'hDEADBEEF) begin failures++; $display("FAIL wstore_ram got %h exp deadbeef", mem[9]); end
    do_req(1'b0, 26'h24, SZ_WORD, 1'b0, 32'h0);
    checks++; if (lat !== 2 || re_cnt !== 1) begin failures++; $display("FAIL wload_latency got lat=%0d re=%0d exp 2/1", lat, re_cnt); end
    checks++; if (LoadData !== 32'hDEADBEEF || flt !== 1'b0) begin failures++; $display("FAIL wload_data got %h f=%b exp deadbeef f=0", LoadData, flt); end
  endtask

  task automatic test_subword_store();
    mem[10] = 32'h11223344;
    do_req(1'b1, 26'h2A, SZ_BYTE, 1'b0, 32'h123456AA);
    checks++; if (lat !== 3 || we_cyc !== 2 || we_cnt !== 1 || re_cnt !== 1) begin failures++; $display("FAIL bstore_timing got lat=%0d wecyc=%0d we=%0d re=%0d exp 3/2/1/1", lat, we_cyc, we_cnt, re_cnt); end
    @(negedge Clk);
    checks++; if (mem[10] !== 32'h11AA3344) begin failures++; $display("FAIL bstore_ram got %h exp 11aa3344", mem[10]); end
    mem[12] = 32'h11223344;
    do_req(1'b1, 26'h32, SZ_HALF, 1'b0, 32'h7777BEEF);
    checks++; if (lat !== 3 || we_addr !== 24'd12) begin failures++; $display("FAIL hstore_timing got lat=%0d addr=%0d exp 3/12", lat, we_addr); end
    @(negedge Clk);
    checks++; if (mem[12] !== 32'hBEEF3344) begin failures++; $display("FAIL hstore_ram got %h exp beef3344", mem[12]); end
  endtask

  task automatic test_loads();
    mem[11] = 32'h8000FF7F;
    do_req(1'b0, 26'h2C, SZ_BYTE, 1'b1, 32'h0);
    checks++; if (LoadData !== 32'h0000007F || lat !== 2) begin failures++; $display("FAIL sbyte_load got %h lat=%0d exp 0000007f lat=2", LoadData, lat); end
    do_req(1'b0, 26'h2E, SZ_HALF, 1'b1, 32'h0);
    checks++; if (LoadData !== 32'hFFFF8000) begin failures++; $display("FAIL shalf_load got %h exp ffff8000", LoadData); end
    do_req(1'b0, 26'h2C, SZ_HALF, 1'b0, 32'h0);
    checks++; if (LoadData !== 32'h0000FF7F) begin failures++; $display("FAIL uhalf_load got %h exp 0000ff7f", LoadData); end
    do_req(1'b0, 26'h2D, SZ_BYTE, 1'b1, 32'h0);
    checks++; if (LoadData !== 32'hFFFFFFFF) begin failures++; $display("FAIL sbyte1_load got %h exp ffffffff", LoadData); end
    do_req(1'b0, 26'h2F, SZ_BYTE, 1'b0, 32'h0);
    checks++; if (LoadData !== 32'h00000080) begin failures++; $display("FAIL ubyte3_load got %h exp 00000080", LoadData); end
  endtask

  task automatic test_fault();
    prev = LoadData;
    do_req(1'b1, 26'h25, SZ_HALF, 1'b0, 32'h1234);
    checks++; if (lat !== 1 || flt !== 1'b1) begin failures++; $display("FAIL hfault got lat=%0d f=%b exp 1/1", lat, flt); end
    checks++; if (we_cnt !== 0 || re_cnt !== 0) begin failures++; $display("FAIL hfault_mem got we=%0d re=%0d exp 0/0", we_cnt, re_cnt); end
    checks++; if (LoadData !== prev) begin failures++; $display("FAIL hfault_hold got %h exp %h", LoadData, prev); end
    do_req(1'b0, 26'h26, SZ_WORD, 1'b0, 32'h0);
    checks++; if (lat !== 1 || flt !== 1'b1 || re_cnt !== 0 || LoadData !== prev) begin failures++; $display("FAIL wfault got lat=%0d f=%b re=%0d ld=%h exp 1/1/0/%h", lat, flt, re_cnt, LoadData, prev); end
    do_req(1'b0, 26'h24, SZ_ILLEGAL, 1'b0, 32'h0);
    checks++; if (lat !== 1 || flt !== 1'b1 || LoadData !== prev) begin failures++; $display("FAIL sizefault got lat=%0d f=%b ld=%h exp 1/1/%h", lat, flt, LoadData, prev); end
  endtask

  task automatic test_back_to_back();
    int done_cnt, first, second;
    logic [31:0] ld1, ld2;
    logic busy_ok;
    done_cnt = 0; first = 0; second = 0; ld1 = 32'h0; ld2 = 32'h0; busy_ok = 1'b1;
    @(negedge Clk);
    Req = 1'b1; Write = 1'b0; Addr = 26'h24; Size = SZ_WORD; Signed = 1'b0;
    @(posedge Clk);
    #1 Addr = 26'h2C;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk);
      if (c == 1 && Ready !== 1'b0) busy_ok = 1'b0;
      if (c == 4) Req = 1'b0;
      if (Done) begin
        done_cnt++;
        if (done_cnt == 1) begin first = c; ld1 = LoadData; end
        else if (done_cnt == 2) begin second = c; ld2 = LoadData; end
      end
    end
    checks++; if (!busy_ok) begin failures++; $display("FAIL b2b_busy got ready=1 exp ready=0"); end
    checks++; if (done_cnt !== 2) begin failures++; $display("FAIL b2b_done_count got %0d exp 2", done_cnt); end
    checks++; if (first !== 2 || second !== 5) begin failures++; $display("FAIL b2b_timing got %0d/%0d exp 2/5", first, second); end
    checks++; if (ld1 !== 32'hDEADBEEF || ld2 !== 32'h8000FF7F) begin failures++; $display("FAIL b2b_data got %h/%h exp deadbeef/8000ff7f", ld1, ld2); end
  endtask

  task automatic test_reset_mid_write();
    mem[13] = 32'h55667788;
    @(negedge Clk);
    Req = 1'b1; Write = 1'b1; Addr = 26'h34; Size = SZ_BYTE; Signed = 1'b0; StoreData = 32'h99;
    @(posedge Clk);
    #1 Req = 1'b0;
    @(posedge Clk);
    #1;
    checks++; if (MemWE !== 1'b1 || MemWriteData !== 32'h55667799) begin failures++; $display("FAIL rmw_write got we=%b d=%h exp 1/55667799", MemWE, MemWriteData); end
    Rst_n = 1'b0;
    #1;
    checks++; if (MemWE !== 1'b0 || Ready !== 1'b1 || MemWriteData !== 32'h0) begin failures++; $display("FAIL rst_mid got we=%b rdy=%b d=%h exp 0/1/0", MemWE, Ready, MemWriteData); end
    @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    checks++; if (mem[13] !== 32'h55667788) begin failures++; $display("FAIL rst_ram got %h exp 55667788", mem[13]); end
    checks++; if (Ready !== 1'b1) begin failures++; $display("FAIL rst_ready got %b exp 1", Ready); end
    do_req(1'b0, 26'h34, SZ_WORD, 1'b0, 32'h0);
    checks++; if (lat !== 2 || LoadData !== 32'h55667788) begin failures++; $display("FAIL rst_reload got lat=%0d %h exp 2/55667788", lat, LoadData); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    test_reset();
    test_word_store_load();
    test_subword_store();
    test_loads();
    test_fault();
    test_back_to_back();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
